uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter (FSM + serializer) among N_REQ byte requesters.

---
 rtl/uart_tx_arbiter.sv | 110 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N_REQ byte requesters.
// Define UART_ARB_LOCK_EN to let a requester holding req_lock keep the bus for its next byte.
module uart_tx_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int IDX_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_lock,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_data_valid,
  input  logic                    tx_busy,
  input  logic                    tx_done,
  output logic [IDX_W-1:0]        active_idx,
  output logic                    arb_busy
);

  // state     | meaning
  // IDLE      | no byte in flight, arbitrate among req
  // LAUNCH    | tx_data_valid held until transmitter reports busy
  // WAIT_DONE | frame in progress, waiting for tx_done
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  cand;
  logic              win_found;
  logic              lock_hold;
  logic [DATA_W-1:0] req_bytes [N_REQ];

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_REQ - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
  end

  // First requesting index at or above ptr, wrapping past N_REQ-1.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
      cand = wrap_inc(cand);
    end
  end

`ifdef UART_ARB_LOCK_EN
  assign lock_hold = req_lock[active_idx] & req[active_idx];
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign lock_hold   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      ptr           <= '0;
      gnt           <= '0;
      done          <= '0;
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
      active_idx    <= '0;
      arb_busy      <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt           <= N_REQ'(1) << win_idx;
            tx_data       <= req_bytes[win_idx];
            active_idx    <= win_idx;
            arb_busy      <= 1'b1;
            tx_data_valid <= 1'b1;
            state         <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (tx_busy) begin
            tx_data_valid <= 1'b0;
            state         <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
            done     <= N_REQ'(1) << active_idx;
            ptr      <= lock_hold ? active_idx : wrap_inc(active_idx);
            arb_busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level reference model plus directed scenarios.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_lock;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_busy;
  logic        tx_done;
  logic [1:0]  active_idx;
  logic        arb_busy;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.N_REQ(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_lock(req_lock),
    .gnt(gnt), .done(done), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .tx_busy(tx_busy), .tx_done(tx_done), .active_idx(active_idx), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: owner of the transmitter, rotating pointer, expected outputs.
  int         m_owner = -1;
  int         m_ptr   = 0;
  int         w;
  logic       keep;
  logic [3:0] e_gnt   = '0;
  logic [3:0] e_done  = '0;
  logic [7:0] e_data  = '0;
  logic [1:0] e_idx   = '0;
  logic       e_valid = 1'b0;
  logic       e_busy  = 1'b0;
  int         m_log[$];
  int         d_log[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner = -1; m_ptr = 0; e_gnt = '0; e_done = '0; e_data = '0;
      e_idx = '0; e_valid = 1'b0; e_busy = 1'b0;
    end else begin
      e_gnt  = '0;
      e_done = '0;
      if (m_owner < 0) begin
        if (req != 4'b0) begin
          w = -1;
          for (int k = 0; k < 4; k++)
            if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
          m_owner = w;
          e_gnt   = 4'(1) << w;
          e_data  = 8'(req_data >> (8 * w));
          e_idx   = 2'(w);
          e_valid = 1'b1;
          e_busy  = 1'b1;
          m_log.push_back(w);
        end
      end else if (e_valid) begin
        if (tx_busy) e_valid = 1'b0;
      end else if (tx_done) begin
`ifdef UART_ARB_LOCK_EN
        keep = req_lock[m_owner] && req[m_owner];
`else
        keep = 1'b0;
`endif
        e_done  = 4'(1) << m_owner;
        m_ptr   = keep ? m_owner : (m_owner + 1) % 4;
        m_owner = -1;
        e_busy  = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("gnt", gnt, e_gnt);
    chk("done", done, e_done);
    chk("tx_data_valid", tx_data_valid, e_valid);
    chk("arb_busy", arb_busy, e_busy);
    if (e_busy) begin
      chk("tx_data", tx_data, e_data);
      chk("active_idx", active_idx, e_idx);
    end
    for (int i = 0; i < 4; i++) if (gnt[i]) d_log.push_back(i);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (tx_data_valid !== 1'b1 && t < 20) begin
      tick(1);
      t++;
    end
    if (tx_data_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: tx_data_valid=%b after 20 cycles, required 1", tx_data_valid);
    end
  endtask

  task automatic accept(input int lat);
    wait_valid();
    if (lat > 0) tick(lat);
    tx_busy = 1'b1;
    tick(1);
  endtask

  task automatic finish(input int len, output logic [3:0] d);
    if (len > 0) tick(len);
    tx_done = 1'b1;
    tick(1);
    d       = done;
    tx_done = 1'b0;
    tx_busy = 1'b0;
  endtask

  task automatic chk_log(input string name, input int exp[5]);
    chk({name, "_model_len"}, m_log.size(), 5);
    chk({name, "_dut_len"}, d_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < m_log.size()) chk({name, "_model_order"}, m_log[i], exp[i]);
      if (i < d_log.size()) chk({name, "_dut_order"}, d_log[i], exp[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] d;
    int exp_rr[5]   = '{0, 1, 2, 3, 0};
`ifdef UART_ARB_LOCK_EN
    int exp_lock[5] = '{0, 0, 0, 1, 0};
`else
    int exp_lock[5] = '{0, 1, 0, 1, 0};
`endif
    rst = 1'b0; req = '0; req_data = '0; req_lock = '0; tx_busy = 1'b0; tx_done = 1'b0;
    tick(2);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_valid", tx_data_valid, 0);
    chk("rst_idx", active_idx, 0);
    chk("rst_busy", arb_busy, 0);
    rst = 1'b1;
    tick(1);

    // single requester, valid held until the transmitter goes busy
    req_data = 32'h0000_00A5; req = 4'b0001;
    tick(1);
    chk("single_gnt", gnt, 4'b0001);
    chk("single_data", tx_data, 8'hA5);
    chk("single_valid", tx_data_valid, 1);
    req = '0; req_data = 32'hFFFF_FFFF;
    tick(2);
    chk("single_valid_held", tx_data_valid, 1);
    chk("single_data_held", tx_data, 8'hA5);
    tx_busy = 1'b1;
    tick(1);
    chk("single_valid_drop", tx_data_valid, 0);
    finish(3, d);
    chk("single_done", d, 4'b0001);
    chk("single_busy_clear", arb_busy, 0);

    // asynchronous reset in the middle of a frame
    req_data = 32'h0033_0000; req = 4'b0100;
    tick(1);
    req = '0;
    accept(0);
    tick(2);
    #2 rst = 1'b0;
    #1;
    chk("abort_gnt", gnt, 0);
    chk("abort_done", done, 0);
    chk("abort_tx_data", tx_data, 0);
    chk("abort_valid", tx_data_valid, 0);
    chk("abort_idx", active_idx, 0);
    chk("abort_busy", arb_busy, 0);
    tx_busy = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(3);
    chk("abort_no_done", done, 0);

    // round robin with all four requesting, pointer starts at 0 after reset
    m_log.delete(); d_log.delete();
    req_data = 32'h4433_2211; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      accept(1);
      finish(2, d);
      chk("rr_done", d, 4'(1) << exp_rr[k]);
    end
    req = '0;
    chk_log("rr", exp_rr);
    tick(2);

    // tx_done and a new request in the same cycle; stray tx_done in LAUNCH and IDLE
    req_data = 32'h0077_005A; req = 4'b0001;
    accept(0);
    req = '0;
    tx_done = 1'b1; req = 4'b0100;
    tick(1);
    chk("simul_done", done, 4'b0001);
    chk("simul_gnt_not_yet", gnt, 0);
    tx_done = 1'b0; tx_busy = 1'b0;
    tick(1);
    chk("simul_gnt", gnt, 4'b0100);
    chk("simul_data", tx_data, 8'h77);
    req = '0;
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    chk("launch_stray_valid", tx_data_valid, 1);
    chk("launch_stray_done", done, 0);
    accept(0);
    finish(1, d);
    chk("simul_done2", d, 4'b0100);
    tick(2);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    chk("idle_stray_gnt", gnt, 0);
    chk("idle_stray_done", done, 0);
    chk("idle_stray_valid", tx_data_valid, 0);
    chk("idle_stray_busy", arb_busy, 0);
    tick(1);

    // lock: requester 0 keeps the bus while req_lock[0] is high (only with the macro)
    #2 rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    m_log.delete(); d_log.delete();
    req_data = 32'h0000_B2B1; req = 4'b0011; req_lock = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      accept(0);
      if (k == 2) req_lock = '0;
      finish(1, d);
      chk("lock_done", d, 4'(1) << exp_lock[k]);
    end
    req = '0;
    chk_log("lock", exp_lock);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
